int_sequencer: RTL

INT_SEQUENCER -- requirements
Module: int_sequencer

---
 rtl/int_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/int_sequencer.sv
// int_sequencer: trap entry / return sequencer for a machine-mode RISC-V core.
// Detects ECALL, EBREAK, MRET and a masked timer interrupt while idle, then walks
// the CSR write sequence (mepc, mcause, mstatus) one write per cycle and emits a
// single-cycle int_flag_o pulse: 8'h01 on trap entry, 8'hFF on trap return.
module int_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        timer_irq_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [31:0] csr_mepc_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [11:0] waddr_o,
  output logic [31:0] data_o,
  output logic [7:0]  int_flag_o,
  output logic [31:0] int_return_addr_o
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned FLAG_W = 8;

  // mstatus bit positions
  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;

  // Instruction encodings recognised in decode
  localparam logic [XLEN-1:0] INST_ECALL  = XLEN'(32'h0000_0073);
  localparam logic [XLEN-1:0] INST_EBREAK = XLEN'(32'h0010_0073);
  localparam logic [XLEN-1:0] INST_MRET   = XLEN'(32'h3020_0073);

  // Trap causes
  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(32'd11);
  localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(32'd3);
  localparam logic [XLEN-1:0] CAUSE_TIMER  = XLEN'(32'h8000_0007);

  // CSR addresses
  localparam logic [CSR_AW-1:0] CSR_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] CSR_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = CSR_AW'(12'h342);

  // int_flag_o codes
  localparam logic [FLAG_W-1:0] FLAG_NONE   = FLAG_W'(8'h00);
  localparam logic [FLAG_W-1:0] FLAG_ENTER  = FLAG_W'(8'h01);
  localparam logic [FLAG_W-1:0] FLAG_RETURN = FLAG_W'(8'hFF);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MCAUSE  = 3'd2,
    S_W_MSTATUS = 3'd3,
    S_ENTER     = 3'd4,
    S_R_MSTATUS = 3'd5,
    S_RETURN    = 3'd6
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [XLEN-1:0]   saved_pc;
  logic [XLEN-1:0]   cause;

  logic              is_ecall;
  logic              is_ebreak;
  logic              is_mret;
  logic              timer_ok;
  logic              event_any;
  logic [XLEN-1:0]   timer_pc;
  logic [XLEN-1:0]   mstatus_enter;
  logic [XLEN-1:0]   mstatus_return;

  // Event decode; the timer is blocked only by a busy ex stage, not by a pending jump
  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign timer_ok  = timer_irq_i & csr_mstatus_i[MIE_BIT] & ~hold_flag_ex_i;
  assign event_any = is_ecall | is_ebreak | is_mret | timer_ok;

  // A pending jump means inst_addr_i will never retire, so resume at the jump target
  assign timer_pc  = jump_flag_i ? jump_addr_i : inst_addr_i;

  // mstatus images for entry (stash MIE in MPIE, clear MIE) and return (restore MIE, set MPIE)
  always_comb begin
    mstatus_enter            = csr_mstatus_i;
    mstatus_enter[MPIE_BIT]  = csr_mstatus_i[MIE_BIT];
    mstatus_enter[MIE_BIT]   = 1'b0;
    mstatus_return           = csr_mstatus_i;
    mstatus_return[MIE_BIT]  = csr_mstatus_i[MPIE_BIT];
    mstatus_return[MPIE_BIT] = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Trap context capture at detection, in the same priority as the next-state logic
  always_ff @(posedge clk) begin
    if (rst) begin
      saved_pc <= '0;
      cause    <= '0;
    end else if (state == S_IDLE) begin
      if (is_ecall) begin
        saved_pc <= inst_addr_i;
        cause    <= CAUSE_ECALL;
      end else if (is_ebreak) begin
        saved_pc <= inst_addr_i;
        cause    <= CAUSE_EBREAK;
      end else if (!is_mret && timer_ok) begin
        saved_pc <= timer_pc;
        cause    <= CAUSE_TIMER;
      end
    end
  end

  // Next-state logic; events outside IDLE are ignored
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (is_ecall || is_ebreak) begin
          state_nxt = S_W_MEPC;
        end else if (is_mret) begin
          state_nxt = S_R_MSTATUS;
        end else if (timer_ok) begin
          state_nxt = S_W_MEPC;
        end
      end
      S_W_MEPC:    state_nxt = S_W_MCAUSE;
      S_W_MCAUSE:  state_nxt = S_W_MSTATUS;
      S_W_MSTATUS: state_nxt = S_ENTER;
      S_ENTER:     state_nxt = S_IDLE;
      S_R_MSTATUS: state_nxt = S_RETURN;
      S_RETURN:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output decode; hold is raised in the detection cycle itself so decode stalls at once
  always_comb begin
    hold_flag_o       = 1'b1;
    we_o              = 1'b0;
    waddr_o           = '0;
    data_o            = '0;
    int_flag_o        = FLAG_NONE;
    int_return_addr_o = '0;
    unique case (state)
      S_IDLE: begin
        hold_flag_o = event_any;
      end
      S_W_MEPC: begin
        we_o    = 1'b1;
        waddr_o = CSR_MEPC;
        data_o  = saved_pc;
      end
      S_W_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = CSR_MCAUSE;
        data_o  = cause;
      end
      S_W_MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = mstatus_enter;
      end
      S_ENTER: begin
        int_flag_o = FLAG_ENTER;
      end
      S_R_MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = mstatus_return;
      end
      S_RETURN: begin
        int_flag_o        = FLAG_RETURN;
        int_return_addr_o = csr_mepc_i;
      end
      default: begin
        hold_flag_o = 1'b0;
      end
    endcase
  end

endmodule
